// File: rtl/light_sequence_scheduler_pkg.sv
// Shared lamp-mode definitions: mode encoding, sweep length, request arbitration.
// Also imported by the downstream lamp FSM so both sides agree on mode_t.
package light_pkg;

   typedef enum logic [2:0] {
      MODE_IDLE   = 3'd0,
      MODE_LEFT   = 3'd1,
      MODE_RIGHT  = 3'd2,
      MODE_HAZARD = 3'd3,
      MODE_BRAKE  = 3'd4,
      MODE_ALARM  = 3'd5
   } mode_t;

   localparam int unsigned N_PHASES = 3;

   // Rank used for preemption: a request only interrupts a strictly lower rank.
   function automatic logic [2:0] mode_prio(input mode_t m);
      case (m)
         MODE_ALARM:  mode_prio = 3'd5;
         MODE_HAZARD: mode_prio = 3'd4;
         MODE_BRAKE:  mode_prio = 3'd3;
         MODE_LEFT:   mode_prio = 3'd2;
         MODE_RIGHT:  mode_prio = 3'd1;
         default:     mode_prio = 3'd0;
      endcase
   endfunction

   function automatic mode_t arbitrate(input logic left, input logic right,
                                       input logic brake, input logic alarm);
      if (alarm)               arbitrate = MODE_ALARM;
      else if (left && right)  arbitrate = MODE_HAZARD;
      else if (brake)          arbitrate = MODE_BRAKE;
      else if (left)           arbitrate = MODE_LEFT;
      else if (right)          arbitrate = MODE_RIGHT;
      else                     arbitrate = MODE_IDLE;
   endfunction

   function automatic logic is_sweep_mode(input mode_t m);
      case (m)
         MODE_LEFT, MODE_RIGHT, MODE_HAZARD, MODE_ALARM: is_sweep_mode = 1'b1;
         default:                                        is_sweep_mode = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/light_sequence_scheduler_if.sv
// Request/status bundle between the driver-request logic and the scheduler.
interface light_sequence_scheduler_if;
   import light_pkg::*;

   logic  left;
   logic  right;
   logic  brake;
   logic  alarm;
   mode_t mode;
   logic  step_en;
   logic  sweep_end;
   logic  busy;

   modport master (output left, right, brake, alarm,
                   input  mode, step_en, sweep_end, busy);
   modport slave  (input  left, right, brake, alarm,
                   output mode, step_en, sweep_end, busy);
endinterface

// File: rtl/light_sequence_scheduler_tick_prescaler.sv
// Free-running step prescaler: tick on the last count of each TICK_DIV window.
module tick_prescaler #(
   parameter int unsigned TICK_DIV = 4
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic run_i,
   input  logic clear_i,
   output logic tick_o
);
   localparam int unsigned   CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: clear wins, otherwise wrap while running, park at zero when idle.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (run_i) begin
         if (cnt_q == LAST) cnt_d = '0;
         else               cnt_d = cnt_q + CW'(1);
      end else begin
         cnt_d = '0;
      end
   end

   // Count register.
   always_ff @(posedge clk_i) begin
      if (reset_i) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign tick_o = run_i && (cnt_q == LAST);
endmodule

// File: rtl/light_sequence_scheduler.sv
// Mode arbiter for the tail-light FSM: fixed-priority requests, minimum sweep
// durations, alarm latching and the step_en / sweep_end strobes.
module light_sequence_scheduler
   import light_pkg::*;
#(
   parameter int unsigned TICK_DIV    = 4,
   parameter int unsigned MIN_SWEEPS  = 1,
   parameter int unsigned ALARM_STEPS = 8
) (
   input logic                        clk_i,
   input logic                        reset_i,
   light_sequence_scheduler_if.slave  bus
);
   localparam int unsigned   PW         = $clog2(N_PHASES);
   localparam logic [PW-1:0] PHASE_LAST = PW'(N_PHASES - 1);
   localparam int unsigned   SW         = $clog2(MIN_SWEEPS + 1);
   localparam int unsigned   SWX        = SW + 1;
   localparam logic [SW-1:0] SWEEP_MAX  = SW'(MIN_SWEEPS);
   localparam int unsigned   AW         = (ALARM_STEPS > 1) ? $clog2(ALARM_STEPS) : 1;
   localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_STEPS - 1);

   mode_t         mode_q, mode_d;
   logic [PW-1:0] phase_q, phase_d;
   logic [SW-1:0] sweeps_q, sweeps_d;
   logic [AW-1:0] alarm_cnt_q, alarm_cnt_d;

   mode_t         req_s;
   logic          run_s, tick_s, sweep_end_s, preempt_s, mode_chg_s;
   logic          release_ok_s, alarm_done_s;
   logic [SW:0]   sweeps_inc_s;

   assign req_s        = arbitrate(bus.left, bus.right, bus.brake, bus.alarm);
   assign run_s        = is_sweep_mode(mode_q);
   assign preempt_s    = mode_prio(req_s) > mode_prio(mode_q);
   assign sweep_end_s  = tick_s && (phase_q == PHASE_LAST);
   // The sweep finishing now counts towards the minimum.
   assign sweeps_inc_s = {1'b0, sweeps_q} + SWX'(1);
   assign release_ok_s = sweep_end_s && (sweeps_inc_s >= SWX'(MIN_SWEEPS));
   assign alarm_done_s = (mode_q == MODE_ALARM) && tick_s && (alarm_cnt_q == ALARM_LAST);
   assign mode_chg_s   = (mode_d != mode_q);

   tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .run_i   (run_s),
      .clear_i (mode_chg_s),
      .tick_o  (tick_s)
   );

   // State register.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         mode_q      <= MODE_IDLE;
         phase_q     <= '0;
         sweeps_q    <= '0;
         alarm_cnt_q <= '0;
      end else begin
         mode_q      <= mode_d;
         phase_q     <= phase_d;
         sweeps_q    <= sweeps_d;
         alarm_cnt_q <= alarm_cnt_d;
      end
   end

   // Next mode and sweep bookkeeping; any mode change restarts every counter.
   always_comb begin
      mode_d = mode_q;
      case (mode_q)
         MODE_IDLE: mode_d = req_s;
         MODE_LEFT, MODE_RIGHT, MODE_HAZARD: begin
            if (preempt_s || release_ok_s) mode_d = req_s;
            else                            mode_d = mode_q;
         end
         MODE_BRAKE: begin
            if (preempt_s || !bus.brake) mode_d = req_s;
            else                         mode_d = mode_q;
         end
         MODE_ALARM: begin
            if (alarm_done_s) mode_d = req_s;
            else              mode_d = mode_q;
         end
         default: mode_d = MODE_IDLE;
      endcase

      phase_d     = phase_q;
      sweeps_d    = sweeps_q;
      alarm_cnt_d = alarm_cnt_q;
      if (mode_d != mode_q) begin
         phase_d     = '0;
         sweeps_d    = '0;
         alarm_cnt_d = '0;
      end else begin
         if (tick_s) phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + PW'(1);
         else        phase_d = phase_q;
         if (sweep_end_s && (sweeps_q != SWEEP_MAX)) sweeps_d = sweeps_q + SW'(1);
         else                                        sweeps_d = sweeps_q;
         // A still-held alarm re-enters with a fresh step budget.
         if (alarm_done_s)                          alarm_cnt_d = '0;
         else if (tick_s && mode_q == MODE_ALARM)   alarm_cnt_d = alarm_cnt_q + AW'(1);
         else                                       alarm_cnt_d = alarm_cnt_q;
      end
   end

   // Outputs decoded from registered state only.
   always_comb begin
      bus.mode      = mode_q;
      bus.step_en   = tick_s;
      bus.sweep_end = sweep_end_s;
      bus.busy      = (mode_q != MODE_IDLE);
   end
endmodule

// File: tb/tb_light_sequence_scheduler.sv
// Scoreboard bench: stimulus queues expected (cycle, mode, strobe) events, a
// negedge monitor pops one whenever mode changes or a strobe fires.
module tb_light_sequence_scheduler;
   logic clk;
   logic reset;
   int   cyc      = 0;
   int   checks   = 0;
   int   failures = 0;
   bit   mon_en   = 1'b0;

   typedef struct {
      int         cyc;
      logic [2:0] mode;
      logic       step;
      logic       send;
      logic       busy;
   } ev_t;

   ev_t        exp_q[$];
   ev_t        cur_e;
   logic [2:0] prev_mode = 3'd0;

   light_sequence_scheduler_if intf ();

   light_sequence_scheduler #(
      .TICK_DIV    (4),
      .MIN_SWEEPS  (1),
      .ALARM_STEPS (6)
   ) dut (
      .clk_i   (clk),
      .reset_i (reset),
      .bus     (intf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void push(input int c, input int m, input bit s, input bit se);
      ev_t n;
      n.cyc  = c;
      n.mode = 3'(m);
      n.step = s;
      n.send = se;
      n.busy = (m != 0);
      exp_q.push_back(n);
   endfunction

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if ((intf.mode != prev_mode) || intf.step_en || intf.sweep_end) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_event: cyc=%0d mode=%0d step=%0b sweep_end=%0b busy=%0b, expected no event",
                        cyc, intf.mode, intf.step_en, intf.sweep_end, intf.busy);
            end else begin
               cur_e = exp_q.pop_front();
               if (cur_e.cyc != cyc || cur_e.mode != intf.mode || cur_e.step != intf.step_en ||
                   cur_e.send != intf.sweep_end || cur_e.busy != intf.busy) begin
                  failures++;
                  $display("FAIL event: got cyc=%0d mode=%0d step=%0b sweep_end=%0b busy=%0b expected cyc=%0d mode=%0d step=%0b sweep_end=%0b busy=%0b",
                           cyc, intf.mode, intf.step_en, intf.sweep_end, intf.busy,
                           cur_e.cyc, cur_e.mode, cur_e.step, cur_e.send, cur_e.busy);
               end
            end
         end
         prev_mode = intf.mode;
      end
   end

   initial begin
      int e;
      int f;
      int g;
      int h;
      reset = 1'b1;
      intf.left  = 1'b0;
      intf.right = 1'b0;
      intf.brake = 1'b0;
      intf.alarm = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_mode", int'(intf.mode), 0);
      check("reset_step_en", int'(intf.step_en), 0);
      check("reset_sweep_end", int'(intf.sweep_end), 0);
      check("reset_busy", int'(intf.busy), 0);
      reset  = 1'b0;
      mon_en = 1'b1;
      wait_until(cyc + 1);

      // 1: single-cycle left request runs one full sweep then idles
      e = cyc + 1;
      intf.left = 1'b1;
      push(e, 1, 0, 0);
      push(e + 3, 1, 1, 0);
      push(e + 7, 1, 1, 0);
      push(e + 11, 1, 1, 1);
      push(e + 12, 0, 0, 0);
      wait_until(e);
      intf.left = 1'b0;
      wait_until(e + 14);

      // 2: brake preempts left, left resumes with a fresh sweep
      e = cyc + 1;
      intf.left = 1'b1;
      push(e, 1, 0, 0);
      push(e + 3, 1, 1, 0);
      push(e + 6, 4, 0, 0);
      wait_until(e + 5);
      intf.brake = 1'b1;
      wait_until(e + 10);
      intf.brake = 1'b0;
      f = e + 11;
      push(f, 1, 0, 0);
      push(f + 3, 1, 1, 0);
      push(f + 7, 1, 1, 0);
      push(f + 11, 1, 1, 1);
      push(f + 12, 0, 0, 0);
      wait_until(f + 4);
      intf.left = 1'b0;
      wait_until(f + 14);

      // 3: left+right on the same edge go straight to hazard, two sweeps
      e = cyc + 1;
      intf.left  = 1'b1;
      intf.right = 1'b1;
      push(e, 3, 0, 0);
      for (int i = 0; i < 6; i++) push(e + 3 + 4 * i, 3, 1, (i % 3) == 2);
      push(e + 24, 0, 0, 0);
      wait_until(e + 19);
      intf.left  = 1'b0;
      intf.right = 1'b0;
      wait_until(e + 26);

      // 4a: alarm pulse latches six steps then idles
      e = cyc + 1;
      intf.alarm = 1'b1;
      push(e, 5, 0, 0);
      for (int i = 0; i < 6; i++) push(e + 3 + 4 * i, 5, 1, (i % 3) == 2);
      push(e + 24, 0, 0, 0);
      wait_until(e);
      intf.alarm = 1'b0;
      wait_until(e + 26);

      // 4b: right raised during alarm waits for the alarm to finish
      g = cyc + 1;
      intf.alarm = 1'b1;
      push(g, 5, 0, 0);
      for (int i = 0; i < 6; i++) push(g + 3 + 4 * i, 5, 1, (i % 3) == 2);
      h = g + 24;
      push(h, 2, 0, 0);
      push(h + 3, 2, 1, 0);
      push(h + 7, 2, 1, 0);
      push(h + 11, 2, 1, 1);
      push(h + 12, 0, 0, 0);
      wait_until(g);
      intf.alarm = 1'b0;
      wait_until(g + 5);
      intf.right = 1'b1;
      wait_until(h + 1);
      intf.right = 1'b0;
      wait_until(h + 14);

      // 5: reset in the middle of right drops to idle with no trailing strobe
      e = cyc + 1;
      intf.right = 1'b1;
      push(e, 2, 0, 0);
      push(e + 3, 2, 1, 0);
      push(e + 7, 0, 0, 0);
      wait_until(e + 6);
      reset = 1'b1;
      wait_until(e + 7);
      reset = 1'b0;
      intf.right = 1'b0;
      wait_until(e + 12);

      // 6: right held 40 cycles, continuous sweeps without restart
      e = cyc + 1;
      intf.right = 1'b1;
      push(e, 2, 0, 0);
      for (int i = 0; i < 12; i++) push(e + 3 + 4 * i, 2, 1, (i % 3) == 2);
      push(e + 48, 0, 0, 0);
      wait_until(e + 39);
      intf.right = 1'b0;
      wait_until(e + 52);

      check("leftover_expected_events", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
